if_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and selects the next PC from the decode stage's pcsource, bpc, jpc and register target.
- Fetches from instruction memory over a single-outstanding request/response interface.
- Buffers fetched words in a small queue and hands {inst, pc4} to decode over a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/if_stage.sv | 127 ++++++++++++
 tb/tb_if_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select codes (also decoded by Control_Unit),
// fetch-stage state encoding and the fetch queue entry layout.
package cpu_pkg;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_REG = 2'b10;
  localparam logic [1:0] PCSEL_J   = 2'b11;

  localparam logic [1:0] IF_IDLE = 2'b00;
  localparam logic [1:0] IF_WAIT = 2'b01;
  localparam logic [1:0] IF_DROP = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with a registered head entry; flush empties it in one
// cycle while the head register keeps showing the last entry.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output fetch_entry_t           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_next;
  logic [CW-1:0]  cnt_pop;
  logic           wr_en;
  fetch_entry_t   head_n;

  assign wr_en      = push & ~flush;
  assign cnt_pop    = count - CW'(pop);
  assign rd_next    = rd_ptr + AW'(pop);
  assign head_valid = (count != '0);

  // Next head: the surviving entry after the pop, else the incoming word.
  always_comb begin
    head_n = head;
    if (cnt_pop != '0) head_n = mem[rd_next];
    else if (wr_en)    head_n = push_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_next;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      count  <= cnt_pop + CW'(wr_en);
      head   <= head_n;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding imem fetch, fetch queue to decode.
// Optional IF_STAT_EN adds stat_fetch/stat_flush counters.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        redirect,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc4,
  output logic [1:0]  dbg_state
`ifdef IF_STAT_EN
  ,
  output logic [31:0] stat_fetch,
  output logic [31:0] stat_flush
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    state, state_n;
  logic [31:0]   pc, pc_n, pc_plus4, target;
  logic [CW-1:0] count, occ_after_pop;
  logic          pop, push, space_idle, space_wait;
  fetch_entry_t  head, push_entry;

  // Handshakes: decode takes the head when id_valid & id_ready at a clock edge;
  // imem_req/imem_addr hold until the single imem_rvalid cycle that answers them.
  assign pop           = id_valid & id_ready & ~redirect;
  assign push          = (state == IF_WAIT) & imem_rvalid & ~redirect;
  assign pc_plus4      = pc + 32'd4;
  assign occ_after_pop = count - CW'(pop);
  assign space_idle    = occ_after_pop < CW'(DEPTH);
  assign space_wait    = (occ_after_pop + CW'(1)) < CW'(DEPTH);
  assign push_entry    = '{inst: imem_rdata, pc4: pc_plus4};

  // A sequential redirect skips past the flushed head.
  always_comb begin
    target = pc;
    case (pcsource)
      PCSEL_SEQ: target = id_valid ? id_pc4 : pc;
      PCSEL_BR:  target = bpc;
      PCSEL_REG: target = rpc;
      PCSEL_J:   target = jpc;
      default:   target = pc;
    endcase
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      IF_IDLE: begin
        if (redirect)        pc_n    = target;
        else if (space_idle) state_n = IF_WAIT;
      end
      IF_WAIT: begin
        if (redirect) begin
          pc_n    = target;
          state_n = imem_rvalid ? IF_IDLE : IF_DROP;
        end else if (imem_rvalid) begin
          pc_n    = pc_plus4;
          state_n = space_wait ? IF_WAIT : IF_IDLE;
        end
      end
      IF_DROP: begin
        if (redirect)    pc_n    = target;
        if (imem_rvalid) state_n = IF_IDLE;
      end
      default: state_n = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IF_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .clr        (clr),
    .push       (push),
    .push_data  (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (id_valid),
    .head       (head)
  );

  assign imem_req  = (state == IF_WAIT);
  assign imem_addr = pc;
  assign id_inst   = head.inst;
  assign id_pc4    = head.pc4;
  assign dbg_state = state;

`ifdef IF_STAT_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      stat_fetch <= '0;
      stat_flush <= '0;
    end else begin
      stat_fetch <= stat_fetch + 32'(push);
      stat_flush <= stat_flush + 32'(redirect);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized redirects, memory
// latency and decode back-pressure against a transaction-level fetch model.
module tb_if_stage;
  import cpu_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, clr, redirect, imem_req, imem_rvalid, id_valid, id_ready;
  logic [1:0]  pcsource, dbg_state;
  logic [31:0] bpc, jpc, rpc, imem_addr, imem_rdata, id_inst, id_pc4;
`ifdef IF_STAT_EN
  logic [31:0] stat_fetch, stat_flush;
`endif

  if_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .redirect    (redirect),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .jpc         (jpc),
    .rpc         (rpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_inst     (id_inst),
    .id_pc4      (id_pc4),
    .dbg_state   (dbg_state)
`ifdef IF_STAT_EN
    ,
    .stat_fetch  (stat_fetch),
    .stat_flush  (stat_flush)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [31:0] fetch_ptr, out_addr, last_inst, last_pc4, data_key;
  logic [31:0] exp_fetch, exp_flush;
  int          remaining, mem_lat, rdy_mode, idle_streak, pops;
  bit          outstanding, stale, rand_redir, force_redir, redir_on_rv;
  logic [1:0]  force_sel;
  logic [31:0] force_tgt;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_inst, s_pc4;
  logic [1:0]  s_state;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ data_key;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    fetch_ptr   = RESET_PC;
    outstanding = 0;
    stale       = 0;
    last_inst   = '0;
    last_pc4    = '0;
    idle_streak = 0;
    pops        = 0;
    force_redir = 0;
    redir_on_rv = 0;
    exp_fetch   = '0;
    exp_flush   = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    clr = 1'b1;
    #1;
    check32("clr_req", imem_req, 1'b0);
    check32("clr_valid", id_valid, 1'b0);
`ifdef IF_STAT_EN
    check32("clr_stat_fetch", stat_fetch, 32'd0);
    check32("clr_stat_flush", stat_flush, 32'd0);
`endif
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    id_ready    = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check32("rst_req", imem_req, 1'b0);
    check32("rst_valid", id_valid, 1'b0);
    check32("rst_inst", id_inst, 32'd0);
    check32("rst_pc4", id_pc4, 32'd0);
    check32("rst_addr", imem_addr, RESET_PC);
    clr = 1'b0;
  endtask

  // One cycle: sample at negedge, compare against the model, play memory and
  // decode, then advance the model by what this cycle's edge will do.
  task automatic step();
    logic        rv, rdy, redir;
    logic [1:0]  sel;
    logic [31:0] tb_v, tj_v, tr_v, tgt;
    logic [63:0] e;
    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = id_valid;
    s_inst  = id_inst;
    s_pc4   = id_pc4;
    s_state = dbg_state;

    check32("id_valid", s_valid, exp_q.size() > 0);
    if (!s_valid) begin
      check32("hold_inst", s_inst, last_inst);
      check32("hold_pc4", s_pc4, last_pc4);
    end
`ifdef IF_STAT_EN
    check32("stat_fetch", stat_fetch, exp_fetch);
    check32("stat_flush", stat_flush, exp_flush);
`endif

    if (s_req && !outstanding) begin
      check32("req_addr", s_addr, fetch_ptr);
      outstanding = 1;
      out_addr    = s_addr;
      remaining   = ((mem_lat == 0) ? int'($urandom_range(1, 3)) : mem_lat) - 1;
    end else if (outstanding && stale) begin
      check32("req_in_drop", s_req, 1'b0);
    end else if (outstanding) begin
      check32("req_held", s_req, 1'b1);
      if (s_req) check32("addr_stable", s_addr, out_addr);
    end

    if (!s_req && !outstanding && exp_q.size() < DEPTH) idle_streak++;
    else idle_streak = 0;
    check32("fetch_stall", idle_streak > 2, 1'b0);

    rv = outstanding && (remaining == 0);
    if (outstanding && !rv) remaining--;
    rdy  = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : rdy_mode[0];
    sel  = 2'($urandom_range(0, 3));
    tb_v = $urandom & 32'hFFFF_FFFC;
    tj_v = $urandom & 32'hFFFF_FFFC;
    tr_v = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 31) == 0) tb_v = 32'hFFFF_FFF8;
    redir = rand_redir && ($urandom_range(0, 15) == 0);
    if (force_redir || (redir_on_rv && rv)) begin
      redir       = 1'b1;
      sel         = force_sel;
      tb_v        = force_tgt;
      tj_v        = force_tgt;
      tr_v        = force_tgt;
      force_redir = 0;
      redir_on_rv = 0;
    end

    id_ready    = rdy;
    redirect    = redir;
    pcsource    = sel;
    bpc         = tb_v;
    jpc         = tj_v;
    rpc         = tr_v;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(out_addr) : $urandom;

    if (s_valid && rdy && !redir && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("pop_inst", s_inst, e[63:32]);
      check32("pop_pc4", s_pc4, e[31:0]);
      pops++;
    end
    if (s_valid) begin
      last_inst = s_inst;
      last_pc4  = s_pc4;
    end
    if (rv) begin
      if (!redir && !stale) begin
        check32("space_rule", exp_q.size() < DEPTH, 1'b1);
        exp_q.push_back({mem_word(out_addr), out_addr + 32'd4});
        fetch_ptr = out_addr + 32'd4;
        exp_fetch++;
      end
      outstanding = 0;
      stale       = 0;
    end
    if (redir) begin
      case (sel)
        PCSEL_SEQ: tgt = (exp_q.size() > 0) ? exp_q[0][31:0] : fetch_ptr;
        PCSEL_BR:  tgt = tb_v;
        PCSEL_REG: tgt = tr_v;
        default:   tgt = tj_v;
      endcase
      fetch_ptr = tgt;
      exp_q.delete();
      if (outstanding) stale = 1;
      idle_streak = 0;
      exp_flush++;
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int n;
    clr = 1'b0; redirect = 1'b0; pcsource = 2'b00; bpc = '0; jpc = '0; rpc = '0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    data_key = '0; mem_lat = 1; rdy_mode = 1; rand_redir = 0;
    force_sel = PCSEL_SEQ; force_tgt = '0;
    model_reset();
    #2;

    // streaming with 1-cycle memory
    do_reset();
    mem_lat = 1; rdy_mode = 1;
    step();
    check32("first_req", s_req, 1'b1);
    check32("first_addr", s_addr, RESET_PC);
    repeat (11) step();
    check32("stream_pc4", s_pc4, 32'd44);
    check32("stream_pops", pops, 32'd11);

    // decode stalled: queue fills, fetch stops, then drains
    do_reset();
    rdy_mode = 0;
    repeat (10) step();
    check32("stall_req", s_req, 1'b0);
    check32("stall_valid", s_valid, 1'b1);
    check32("stall_inst", s_inst, 32'h0);
    check32("stall_pc4", s_pc4, 32'h4);
    rdy_mode = 1;
    repeat (2) step();
    check32("resume_req", s_req, 1'b1);
    check32("resume_addr", s_addr, 32'h8);
    check32("resume_pc4", s_pc4, 32'h8);

    // branch while a slow fetch is outstanding
    do_reset();
    mem_lat = 3; force_redir = 1; force_sel = PCSEL_BR; force_tgt = 32'h100;
    step();
    step();
    check32("drop_state", s_state, IF_DROP);
    n = 0;
    while (!s_req && n < 10) begin step(); n++; end
    check32("bpc_req", s_req, 1'b1);
    check32("bpc_addr", s_addr, 32'h100);

    // jump coinciding with the response
    do_reset();
    mem_lat = 2; redir_on_rv = 1; force_sel = PCSEL_J; force_tgt = 32'h2000;
    repeat (2) step();
    n = 0;
    do begin step(); n++; end while (!s_req && n < 10);
    check32("jpc_req", s_req, 1'b1);
    check32("jpc_addr", s_addr, 32'h2000);
    check32("jpc_empty", s_valid, 1'b0);

    // fetch at the top of the address space wraps pc4 to 0
    mem_lat = 1; force_redir = 1; force_sel = PCSEL_BR; force_tgt = 32'hFFFF_FFFC;
    step();
    n = 0;
    do begin step(); n++; end while (!s_valid && n < 12);
    check32("wrap_inst", s_inst, 32'hFFFF_FFFC);
    check32("wrap_pc4", s_pc4, 32'h0);
    check32("wrap_next_req", s_req, 1'b1);
    check32("wrap_next_addr", s_addr, 32'h0);

    // sequential redirect with a full queue resumes at the head's pc4
    do_reset();
    rdy_mode = 0; mem_lat = 1;
    repeat (10) step();
    force_redir = 1; force_sel = PCSEL_SEQ; force_tgt = 32'h0BAD_0000;
    step();
    rdy_mode = 1;
    n = 0;
    do begin step(); n++; end while (!s_valid && n < 12);
    check32("seq_inst", s_inst, 32'h4);
    check32("seq_pc4", s_pc4, 32'h8);

    // asynchronous reset in the middle of a fetch
    do_reset();
    mem_lat = 3;
    repeat (2) step();
    check32("pre_clr_req", s_req, 1'b1);
    do_reset();
    step();
    check32("restart_req", s_req, 1'b1);
    check32("restart_addr", s_addr, RESET_PC);

    // randomized traffic
    data_key = $urandom;
    do_reset();
    mem_lat = 0; rdy_mode = 2; rand_redir = 1;
    repeat (3000) step();
    check32("rand_progress", pops > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
